// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared widths and enums for the multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ITER_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
// Module   : mdu_core
// Brief    : Unsigned shift-add multiply / restoring divide step datapath.
//            Divider step compiled in only when MDU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_core
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] sr_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    // acc holds the running upper product / partial remainder,
    // sr holds the multiplier / dividend-into-quotient shift register.
    logic [XLEN:0]   acc_q, acc_d;
    logic [XLEN-1:0] sr_q, sr_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN:0]   add_sum;
    logic            step_en;

    assign add_sum = sr_q[0] ? (acc_q + {1'b0, opd_q}) : acc_q;

`ifdef MDU_DIV_EN
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] rem_diff;

    assign rem_shift = {acc_q[XLEN-1:0], sr_q[XLEN-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, opd_q};
    assign step_en   = step_i;
`else
    // A divide can never reach CALC in this build; guard anyway.
    assign step_en   = step_i & ~div_i;
`endif

    always_comb begin
        acc_d = acc_q;
        sr_d  = sr_q;
        opd_d = opd_q;
        if (load_i) begin
            acc_d = '0;
            sr_d  = sr_i;
            opd_d = opd_i;
        end else if (step_en) begin
`ifdef MDU_DIV_EN
            if (div_i) begin
                if (rem_diff[XLEN+1]) begin
                    acc_d = rem_shift;
                    sr_d  = {sr_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = rem_diff[XLEN:0];
                    sr_d  = {sr_q[XLEN-2:0], 1'b1};
                end
            end else
`endif
            begin
                {acc_d, sr_d} = {1'b0, add_sum, sr_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sr_q  <= '0;
            opd_q <= '0;
        end else begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            opd_q <= opd_d;
        end
    end

    assign hi_o = acc_q[XLEN-1:0];
    assign lo_o = sr_q;

endmodule : mdu_core
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Brief    : Iterative MULT/MULTU/DIV/DIVU controller with HI/LO registers.
//            Define MDU_DIV_EN to compile in the divider.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            hilo_rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            stall_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mdu_state_e       state_q;
    mdu_op_e          op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic             done_q;
    logic             err_q;

    logic             signed_op;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             accept;
    logic             load;
    logic             op_q_div;
    logic [XLEN-1:0]  core_hi;
    logic [XLEN-1:0]  core_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  fix_hi;
    logic [XLEN-1:0]  fix_lo;

    assign busy_o  = (state_q == CALC) || (state_q == FIX);
    assign stall_o = busy_o & (hilo_rd_i | start_i);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign neg_a     = signed_op & a_i[XLEN-1];
    assign neg_b     = signed_op & b_i[XLEN-1];
    assign a_mag     = neg_a ? -a_i : a_i;
    assign b_mag     = neg_b ? -b_i : b_i;
    assign accept    = start_i & ~flush_i & ~busy_o;

`ifdef MDU_DIV_EN
    assign load = accept & (~is_div | (b_i != '0));
`else
    assign load = accept & ~is_div;
`endif

    assign op_q_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    mdu_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .step_i (state_q == CALC),
        .div_i  (op_q_div),
        .sr_i   (is_div ? a_mag : b_mag),
        .opd_i  (is_div ? b_mag : a_mag),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    // Sign correction applied to the unsigned core result in FIX.
    always_comb begin
        prod = {core_hi, core_lo};
        if ((op_q == OP_MULT) && (sign_a_q ^ sign_b_q)) begin
            prod = -prod;
        end
        fix_hi = prod[2*XLEN-1:XLEN];
        fix_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (op_q_div) begin
            fix_lo = ((op_q == OP_DIV) && (sign_a_q ^ sign_b_q)) ? -core_lo : core_lo;
            fix_hi = ((op_q == OP_DIV) && sign_a_q) ? -core_hi : core_hi;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q     <= mdu_op_e'(op_i);
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        cnt_q    <= '0;
                        if (load) begin
                            state_q <= CALC;
                        end else begin
                            // Divide-by-zero, or divide with the divider absent.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
`ifdef MDU_DIV_EN
                            hi_q    <= a_i;
                            lo_q    <= '1;
`endif
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
            endcase
        end
    end

endmodule : mdu_ctrl
`default_nettype wire
